// File: rtl/decimal_key_scanner.sv
// decimal_key_scanner: 4x3 matrix keypad scanner with debounce.
// It drives one keypad column low at a time and synchronises the row lines.
// A single pressed key is debounced for both press and release. Digits are
// presented as a registered one-hot bus d_out[9:0], and each accepted press
// gives a one-cycle key_strobe.
// Optional feature macro: KEYPAD_FUNC_KEYS_EN. When defined, '*' and '#' are
// accepted and reported on func_key. When undefined they are treated as no
// key, and func_key is tied low.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SCAN     | rotate column drive, sample rows at the end of each dwell
// ST_DEBOUNCE | column frozen, count consecutive cycles matching the capture
// ST_HELD     | key reported, waiting for a debounced full release

module decimal_key_scanner #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CNT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [2:0] col_n,
   output logic [9:0] d_out,
   output logic       key_strobe,
   output logic       busy,
   output logic [1:0] func_key
);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

`ifdef KEYPAD_FUNC_KEYS_EN
   localparam bit FUNC_EN = 1'b1;
`else
   localparam bit FUNC_EN = 1'b0;
`endif

   // Key codes 0..9 are digits. Codes 10 and 11 are '*' and '#'. Code 15
   // means no decodable key.
   localparam logic [3:0] CODE_STAR = 4'd10;
   localparam logic [3:0] CODE_HASH = 4'd11;
   localparam logic [3:0] CODE_NONE = 4'd15;

   logic [3:0]    row_meta_q;
   logic [3:0]    row_s;

   state_t        state_q,    state_d;
   logic [2:0]    col_n_q,    col_n_d;
   logic [DW-1:0] dwell_q,    dwell_d;
   logic [CW-1:0] deb_q,      deb_d;
   logic [CW-1:0] rel_q,      rel_d;
   logic [3:0]    row_cap_q,  row_cap_d;
   logic [3:0]    key_code_q, key_code_d;
   logic [9:0]    d_out_q,    d_out_d;
   logic          strobe_q,   strobe_d;
   logic          busy_q,     busy_d;
`ifdef KEYPAD_FUNC_KEYS_EN
   logic [1:0]    func_q,     func_d;
`endif

   logic          one_low;
   logic [1:0]    row_idx;
   logic [1:0]    col_idx;
   logic [3:0]    key_code;
   logic          key_ok;
   logic [2:0]    col_next;

   // Two-flop synchroniser for the asynchronous, pulled-up row lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_s      <= 4'hF;
      end else begin
         row_meta_q <= row_n;
         row_s      <= row_meta_q;
      end
   end

   // Decode the synchronised rows and current column into a key code.
   always_comb begin
      one_low = 1'b1;
      row_idx = 2'd0;
      unique case (row_s)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: one_low = 1'b0;
      endcase

      col_idx = 2'd3;
      unique case (col_n_q)
         3'b110:  col_idx = 2'd0;
         3'b101:  col_idx = 2'd1;
         3'b011:  col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase

      key_code = CODE_NONE;
      case ({row_idx, col_idx})
         4'b00_00: key_code = 4'd1;
         4'b00_01: key_code = 4'd2;
         4'b00_10: key_code = 4'd3;
         4'b01_00: key_code = 4'd4;
         4'b01_01: key_code = 4'd5;
         4'b01_10: key_code = 4'd6;
         4'b10_00: key_code = 4'd7;
         4'b10_01: key_code = 4'd8;
         4'b10_10: key_code = 4'd9;
         4'b11_00: key_code = CODE_STAR;
         4'b11_01: key_code = 4'd0;
         4'b11_10: key_code = CODE_HASH;
         default:  key_code = CODE_NONE;
      endcase

      key_ok = one_low &&
               ((key_code < 4'd10) ||
                (FUNC_EN && ((key_code == CODE_STAR) || (key_code == CODE_HASH))));

      col_next = {col_n_q[1:0], col_n_q[2]};
   end

   // Next-state logic for the scan / debounce / held sequencer.
   always_comb begin
      state_d    = state_q;
      col_n_d    = col_n_q;
      dwell_d    = dwell_q;
      deb_d      = deb_q;
      rel_d      = rel_q;
      row_cap_d  = row_cap_q;
      key_code_d = key_code_q;
      d_out_d    = d_out_q;
      strobe_d   = 1'b0;
`ifdef KEYPAD_FUNC_KEYS_EN
      func_d     = func_q;
`endif

      unique case (state_q)
         ST_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (key_ok) begin
                  // Freeze the column so the captured row pattern stays comparable.
                  state_d    = ST_DEBOUNCE;
                  row_cap_d  = row_s;
                  key_code_d = key_code;
                  deb_d      = '0;
               end else begin
                  col_n_d = col_next;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (row_s == row_cap_q) begin
               if (deb_q == DEB_LAST) begin
                  state_d  = ST_HELD;
                  rel_d    = '0;
                  strobe_d = 1'b1;
                  if (key_code_q < 4'd10) begin
                     d_out_d = 10'b1 << key_code_q;
                  end else begin
                     d_out_d = '0;
`ifdef KEYPAD_FUNC_KEYS_EN
                     func_d  = {key_code_q == CODE_HASH, key_code_q == CODE_STAR};
`endif
                  end
               end else begin
                  deb_d = deb_q + CW'(1);
               end
            end else begin
               state_d = ST_SCAN;
               col_n_d = col_next;
               dwell_d = '0;
               deb_d   = '0;
            end
         end

         ST_HELD: begin
            // Any low row, including a second key, restarts the release count.
            if (row_s == 4'hF) begin
               if (rel_q == DEB_LAST) begin
                  state_d = ST_SCAN;
                  col_n_d = 3'b110;
                  dwell_d = '0;
                  rel_d   = '0;
                  d_out_d = '0;
`ifdef KEYPAD_FUNC_KEYS_EN
                  func_d  = 2'b00;
`endif
               end else begin
                  rel_d = rel_q + CW'(1);
               end
            end else begin
               rel_d = '0;
            end
         end

         default: begin
            state_d = ST_SCAN;
            col_n_d = 3'b110;
            dwell_d = '0;
         end
      endcase

      busy_d = (state_d != ST_SCAN);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_SCAN;
         col_n_q    <= 3'b110;
         dwell_q    <= '0;
         deb_q      <= '0;
         rel_q      <= '0;
         row_cap_q  <= 4'hF;
         key_code_q <= CODE_NONE;
         d_out_q    <= '0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef KEYPAD_FUNC_KEYS_EN
         func_q     <= 2'b00;
`endif
      end else begin
         state_q    <= state_d;
         col_n_q    <= col_n_d;
         dwell_q    <= dwell_d;
         deb_q      <= deb_d;
         rel_q      <= rel_d;
         row_cap_q  <= row_cap_d;
         key_code_q <= key_code_d;
         d_out_q    <= d_out_d;
         strobe_q   <= strobe_d;
         busy_q     <= busy_d;
`ifdef KEYPAD_FUNC_KEYS_EN
         func_q     <= func_d;
`endif
      end
   end

   assign col_n      = col_n_q;
   assign d_out      = d_out_q;
   assign key_strobe = strobe_q;
   assign busy       = busy_q;
`ifdef KEYPAD_FUNC_KEYS_EN
   assign func_key   = func_q;
`else
   assign func_key   = 2'b00;
`endif

endmodule

// File: tb/tb_decimal_key_scanner.sv
// Testbench for decimal_key_scanner with SCAN_DIV=4 and DEBOUNCE_CNT=8.
// A behavioural keypad model pulls rows low for the pressed keys in the driven column.
// Key mask index = row*3 + col: '1'=0 .. '9'=8, '*'=9, '0'=10, '#'=11.

module tb_decimal_key_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_n;
   logic [2:0]  col_n;
   logic [9:0]  d_out;
   logic        key_strobe;
   logic        busy;
   logic [1:0]  func_key;

   logic [11:0] key_mask;
   int          checks = 0;
   int          errors = 0;
   int          strobes = 0;

   decimal_key_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .row_n      (row_n),
      .col_n      (col_n),
      .d_out      (d_out),
      .key_strobe (key_strobe),
      .busy       (busy),
      .func_key   (func_key)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (key_mask[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   task automatic tick();
      @(negedge clk);
      if (key_strobe) strobes++;
   endtask

   task automatic test_reset();
      logic [2:0] cols [3];
      logic [2:0] exp_col;
      cols = '{3'b110, 3'b101, 3'b011};
      key_mask = '0;
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({col_n, d_out, key_strobe, busy, func_key} !== {3'b110, 10'b0, 1'b0, 1'b0, 2'b00}) begin
         errors++;
         $display("FAIL reset_values: col_n=%b d_out=%b strobe=%b busy=%b func=%b", col_n, d_out, key_strobe, busy, func_key);
      end
      rst = 1'b0;
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) tick();
         exp_col = cols[(i/4)%3];
         checks++;
         if ({col_n, d_out, key_strobe, busy} !== {exp_col, 10'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_scan[%0d]: col_n=%b d_out=%b strobe=%b busy=%b expected col_n=%b others 0", i, col_n, d_out, key_strobe, busy, exp_col);
         end
      end
   endtask

   task automatic test_key5();
      bit found = 0;
      bit bad = 0;
      strobes = 0;
      key_mask = 12'b1 << 4;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (key_strobe) found = 1;
      end
      checks++;
      if (found !== 1'b1) begin errors++; $display("FAIL key5_strobe: no strobe within 40 cycles"); end
      checks++;
      if (d_out !== 10'b0000100000) begin errors++; $display("FAIL key5_dout: got %b want 0000100000", d_out); end
      checks++;
      if (col_n !== 3'b101 || busy !== 1'b1) begin errors++; $display("FAIL key5_col_busy: col_n=%b busy=%b want 101/1", col_n, busy); end
      for (int n = 0; n < 30; n++) begin
         if (n == 10) key_mask = (12'b1 << 4) | (12'b1 << 1);
         if (n == 18) key_mask = 12'b1 << 4;
         tick();
         if (d_out !== 10'b0000100000 || col_n !== 3'b101 || busy !== 1'b1) bad = 1;
      end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL key5_hold: d_out/col_n/busy changed while held (d_out=%b)", d_out); end
      checks++;
      if (strobes != 1) begin errors++; $display("FAIL key5_single_strobe: got %0d want 1", strobes); end
      key_mask = '0;
      repeat (4) tick();
      checks++;
      if (d_out !== 10'b0000100000) begin errors++; $display("FAIL key5_release_hold: got %b want 0000100000", d_out); end
      repeat (12) tick();
      checks++;
      if (d_out !== 10'b0 || busy !== 1'b0) begin errors++; $display("FAIL key5_released: d_out=%b busy=%b want 0/0", d_out, busy); end
   endtask

   task automatic test_bounce();
      bit found = 0;
      strobes = 0;
      for (int k = 0; k < 4; k++) begin
         key_mask = (k % 2 == 0) ? (12'b1 << 6) : 12'b0;
         repeat (3) tick();
      end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL bounce_no_strobe: got %0d strobes want 0", strobes); end
      key_mask = 12'b1 << 6;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (key_strobe) found = 1;
      end
      checks++;
      if (found !== 1'b1) begin errors++; $display("FAIL bounce_strobe: no strobe within 40 stable cycles"); end
      checks++;
      if (d_out !== 10'b0010000000) begin errors++; $display("FAIL bounce_dout: got %b want 0010000000", d_out); end
      repeat (10) tick();
      checks++;
      if (strobes != 1) begin errors++; $display("FAIL bounce_single_strobe: got %0d want 1", strobes); end
      key_mask = '0;
      repeat (16) tick();
      checks++;
      if (d_out !== 10'b0 || busy !== 1'b0) begin errors++; $display("FAIL bounce_released: d_out=%b busy=%b want 0/0", d_out, busy); end
   endtask

   task automatic test_two_keys();
      bit found = 0;
      bit saw_col2 = 0;
      bit busy_seen = 0;
      strobes = 0;
      key_mask = (12'b1 << 0) | (12'b1 << 3);
      repeat (30) begin
         tick();
         if (col_n === 3'b011) saw_col2 = 1;
         if (busy === 1'b1) busy_seen = 1;
      end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL two_keys_no_strobe: got %0d want 0", strobes); end
      checks++;
      if (busy_seen !== 1'b0) begin errors++; $display("FAIL two_keys_busy: busy went high, want 0"); end
      checks++;
      if (saw_col2 !== 1'b1) begin errors++; $display("FAIL two_keys_scanning: col_n never reached 011"); end
      key_mask = 12'b1 << 0;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (key_strobe) found = 1;
      end
      checks++;
      if (found !== 1'b1 || d_out !== 10'b0000000010) begin errors++; $display("FAIL two_keys_release4: found=%b d_out=%b want 1/0000000010", found, d_out); end
      key_mask = '0;
      repeat (16) tick();
   endtask

   task automatic test_rst_mid_press();
      bit found = 0;
      key_mask = 12'b1 << 10;
      for (int n = 0; n < 40 && !found; n++) begin
         tick();
         if (key_strobe) found = 1;
      end
      checks++;
      if (found !== 1'b1 || d_out !== 10'b0000000001) begin errors++; $display("FAIL rst_pre_held: found=%b d_out=%b want 1/0000000001", found, d_out); end
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (d_out !== 10'b0 || col_n !== 3'b110 || busy !== 1'b0 || key_strobe !== 1'b0) begin
         errors++;
         $display("FAIL rst_values: d_out=%b col_n=%b busy=%b strobe=%b want 0/110/0/0", d_out, col_n, busy, key_strobe);
      end
      strobes = 0;
      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i == 15) begin
            checks++;
            if (key_strobe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rst_latency_early: strobe=%b busy=%b want 0/1", key_strobe, busy); end
         end
         if (i == 16) begin
            checks++;
            if (key_strobe !== 1'b1 || d_out !== 10'b0000000001) begin errors++; $display("FAIL rst_latency_strobe: strobe=%b d_out=%b want 1/0000000001", key_strobe, d_out); end
         end
      end
      checks++;
      if (strobes != 1 || key_strobe !== 1'b0) begin errors++; $display("FAIL rst_one_strobe: strobes=%0d strobe_now=%b want 1/0", strobes, key_strobe); end
      key_mask = '0;
      repeat (16) tick();
      checks++;
      if (d_out !== 10'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_released: d_out=%b busy=%b want 0/0", d_out, busy); end
   endtask

   task automatic test_hash();
      bit found = 0;
      bit func_seen = 0;
      logic [1:0] func_at = 2'b00;
      logic [9:0] dout_at = '0;
      strobes = 0;
      key_mask = 12'b1 << 11;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (func_key !== 2'b00) func_seen = 1;
         if (key_strobe && !found) begin
            found = 1;
            func_at = func_key;
            dout_at = d_out;
         end
      end
`ifdef KEYPAD_FUNC_KEYS_EN
      checks++;
      if (strobes != 1) begin errors++; $display("FAIL hash_strobe: got %0d strobes want 1", strobes); end
      checks++;
      if (func_at !== 2'b10 || dout_at !== 10'b0) begin errors++; $display("FAIL hash_func: func_key=%b d_out=%b want 10/0", func_at, dout_at); end
`else
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL hash_no_strobe: got %0d strobes want 0", strobes); end
      checks++;
      if (func_seen !== 1'b0) begin errors++; $display("FAIL hash_func_zero: func_key went nonzero, want 00"); end
`endif
      key_mask = '0;
      repeat (16) tick();
      checks++;
      if (func_key !== 2'b00 || d_out !== 10'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hash_released: func_key=%b d_out=%b busy=%b want 00/0/0", func_key, d_out, busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      key_mask = '0;
      test_reset();
      test_key5();
      test_bounce();
      test_two_keys();
      test_rst_mid_press();
      test_hash();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
